// File: rtl/shift_sub_divider.sv
// Unsigned restoring divider: one shift/subtract step per clock.
// Results and flags are registered and only update when a division completes.
module shift_sub_divider #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero
);

   localparam int CW = $clog2(N + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [N:0]    r_reg;
   logic [N-1:0]  q_reg;
   logic [N-1:0]  d_reg;
   logic [CW-1:0] cnt;

   logic [N:0]    r_sh;
   logic [N+1:0]  diff;
   logic          borrow;
   logic [N:0]    r_next;
   logic [N-1:0]  q_next;
   logic          last_step;

   // Partial remainder stays below the divisor, so r_reg[N] is always 0; it is
   // still folded into the borrow test so a set top bit would never borrow.
   always_comb begin
      r_sh      = {r_reg[N-1:0], q_reg[N-1]};
      diff      = {1'b0, r_sh} - {2'b00, d_reg};
      borrow    = diff[N+1] & ~r_reg[N];
      r_next    = r_sh;
      q_next    = {q_reg[N-2:0], 1'b0};
      if (!borrow) begin
         r_next = diff[N:0];
         q_next = {q_reg[N-2:0], 1'b1};
      end
      last_step = (cnt == CW'(1)) || (cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         r_reg       <= '0;
         q_reg       <= '0;
         d_reg       <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_reg <= '0;
                  q_reg <= dividend;
                  d_reg <= divisor;
                  cnt   <= CW'(N);
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               r_reg <= r_next;
               q_reg <= q_next;
               if (cnt != '0) cnt <= cnt - CW'(1);
               // Final step: publish the freshly computed values on the same edge
               if (last_step) begin
                  quotient    <= q_next;
                  remainder   <= r_next[N-1:0];
                  div_by_zero <= (d_reg == '0);
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/shift_sub_divider.md
SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width in bits (N >= 2).
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-003 The block SHALL have port clk, input, 1 bit, rising-edge system clock.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, a request to begin a division, sampled only in IDLE.
REQ-006 The block SHALL have port dividend, input, N bits, unsigned dividend, sampled with start.
REQ-007 The block SHALL have port divisor, input, N bits, unsigned divisor, sampled with start.
REQ-008 The block SHALL have port quotient, output, N bits, registered result.
REQ-009 The block SHALL have port remainder, output, N bits, registered result.
REQ-010 The block SHALL have port busy, output, 1 bit, high while in CALC.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle pulse when results become valid.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit, registered flag for the last division.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, CALC and DONE.
REQ-014 Transitions:
- IDLE->CALC on start=1.
- CALC->DONE when the iteration counter reaches 0.
- DONE->IDLE unconditionally after one cycle.
REQ-015 On accepting start, the block SHALL clear the partial remainder R (N+1 bits) to 0, load dividend into Q, latch divisor into D, and load the down-counter with N.
REQ-016 Each CALC cycle SHALL perform one restoring step:
- shift {R,Q} left one bit;
- compute T = R - {0,D} in N+1 bits;
- if no borrow, R = T and Q[0] = 1; otherwise R is unchanged and Q[0] = 0;
- decrement the counter.
REQ-017 Exactly N iterations SHALL occur; the counter SHALL NOT wrap below 0.
REQ-018 On the CALC->DONE edge, quotient SHALL load Q, remainder SHALL load R[N-1:0], and div_by_zero SHALL load (D==0).
REQ-019 done SHALL be 1 only in DONE; latency from the start-sampling edge to done=1 SHALL be N+1 cycles.
REQ-020 quotient, remainder and div_by_zero SHALL hold their last values through IDLE and CALC until the next CALC->DONE edge.
REQ-021 start SHALL be ignored in CALC and DONE; no queuing.
REQ-022 start asserted in the first IDLE cycle after DONE SHALL be accepted; the back-to-back period SHALL be N+2 cycles.
REQ-023 A divisor of 0 SHALL run the normal N iterations and yield quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-024 Dividend or divisor changes after start is sampled SHALL NOT affect the result in progress.
REQ-025 The results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every divisor != 0.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and clear R, Q, D, the counter, quotient, remainder, busy, done and div_by_zero to 0.
REQ-027 rst SHALL take priority over start and over any in-progress step.
REQ-028 A reset in CALC or DONE SHALL abort the division with no done pulse.

Verification
REQ-029 N=4, dividend=13, divisor=3, start pulsed once -> busy=1 for 4 cycles, done=1 on cycle 5, quotient=4, remainder=1, div_by_zero=0.
REQ-030 N=4: 15/1 -> quotient=15, remainder=0; 5/7 -> quotient=0, remainder=5; 0/9 -> quotient=0, remainder=0.
REQ-031 N=4, dividend=9, divisor=0 -> quotient=15, remainder=9, div_by_zero=1, done on cycle 5.
REQ-032 rst=1 during the 2nd CALC cycle of 13/3 -> IDLE next cycle, all outputs 0, no done pulse; a fresh 13/3 afterwards -> 4 r 1.
REQ-033 The following SHALL be checked:
- start held high through CALC with inputs changed mid-operation -> result unchanged from the sampled operands, and a single done pulse;
- start in the cycle after done -> second result 5 cycles later;
- N=8 random sweep -> REQ-025 holds.
